decode_hazard_unit: RTL and testbench
=====================================

Name: decode_hazard_unit

Overview:
Decode-side counterpart of the fetch stage. It consumes fetch's PC/IR/valid, detects branches and register hazards, and drives the branch-stall and dependency-stall signals back to fetch. It issues decoded instructions, or bubbles, to the next stage. A 16-entry scoreboard tracks in-flight register writers and is cleared by writeback.

Parameters:
NUM_REGS, 16, architectural registers (scoreboard depth)
REG_IDX_W, 4, register index width
NOP_IR, 32'hFF000000, bubble encoding driven downstream

Ports:
I_CLOCK  in  1  clock; all state updates on negedge I_CLOCK
I_RESET  in  1  asynchronous, active-high reset
I_LOCK  in  1  pipeline run enable; 0 = idle
I_PC  in  `PC_WIDTH  PC from fetch
I_IR  in  `IR_WIDTH  instruction from fetch
I_FE_Valid  in  1  fetch output valid
I_BranchAddrSelect  in  1  branch resolved (from memory stage)
I_GPUStallSignal  in  1  downstream freeze
I_WB_Valid  in  1  writeback retiring a register write
I_WB_DestReg  in  REG_IDX_W  register being written back
O_LOCK  out  1  registered copy of I_LOCK
O_BranchStallSignal  out  1  to fetch
O_DepStallSignal  out  1  to fetch, combinational
O_DE_Valid  out  1  issued instruction valid
O_PC  out  `PC_WIDTH  issued PC
O_IR  out  `IR_WIDTH  issued IR, NOP_IR when bubble
O_DestReg  out  REG_IDX_W  destination of issued instruction
O_DestValid  out  1  issued instruction writes O_DestReg

Behaviour:
- Reset (async): all scoreboard bits 0; O_BranchStallSignal=0, O_DE_Valid=0, O_PC=0, O_IR=NOP_IR, O_DestReg=0, O_DestValid=0, O_LOCK=0.
- Field decode: opcode=IR[31:24], dst=IR[23:20], src1=IR[19:16], src2=IR[15:12]. Opcode classes (writes-dst, reads-src1, reads-src2, is-branch) come from shared constants. Opcode 8'hFF is a bubble and is never a hazard.
- hazard = I_FE_Valid & !bubble & (RAW on any read source | WAW on dst), checked against busy_eff.
  - busy_eff = busy & ~(I_WB_Valid-decoded one-hot), so a same-cycle writeback is forwarded.
- O_DepStallSignal = I_LOCK & hazard & !O_BranchStallSignal (combinational).
- Issue condition: I_LOCK & I_FE_Valid & !hazard & !O_BranchStallSignal & !I_GPUStallSignal & !bubble.
  - On issue: outputs take I_PC/I_IR/dst, O_DE_Valid=1, and busy[dst] is set when the opcode writes dst.
  - Otherwise: O_DE_Valid=0, O_IR=NOP_IR, O_DestValid=0.
- Branch state machine:
  - IDLE -> BR_PEND when a branch issues; O_BranchStallSignal=1 from the next edge.
  - BR_PEND -> IDLE on I_BranchAddrSelect.
  - In BR_PEND, fetch input is discarded (no issue, no scoreboard set).
  - Simultaneous branch issue and I_BranchAddrSelect: resolve wins for the old branch; the new branch still enters BR_PEND.
- I_GPUStallSignal=1: all outputs and scoreboard set-side hold. Writeback clears still apply. O_DepStallSignal is forced 1 to hold fetch.
- Scoreboard: writeback clear and issue set on the same register in the same edge -> set wins (bit stays 1).
- I_LOCK=0: emit bubbles, state FSM IDLE, scoreboard held.
- Reset mid-branch: returns to IDLE, stall drops immediately (async).

Optional Feature:
DE_WB_BYPASS_EN
- Defined: busy_eff masks the same-cycle writeback as above.
- Undefined: busy_eff=busy. A dependent instruction stalls one extra cycle until the bit clears at the edge.

Decomposition:
- Opcode constants, class-membership macros, field bit positions and NOP_IR go in the shared global_def.h.
- Natural sub-module: decode_scoreboard, holding the NUM_REGS busy bits with set/clear/query ports and the bypass mux.

Test Plan:
- Reset during BR_PEND with busy[3]=1 -> all outputs at reset values, O_BranchStallSignal=0 immediately, busy all 0.
- ADD R1,R2,R3 issued then ADD R4,R1,R1 next cycle, no WB -> O_DepStallSignal=1, O_IR=32'hFF000000 until I_WB_Valid with I_WB_DestReg=1.
  - Bypass on: issues in the WB cycle.
  - Bypass off: issues one cycle later.
- Branch at PC 16'h0010 -> O_BranchStallSignal=1 next edge. Valid fetch inputs are dropped (O_DE_Valid=0) until I_BranchAddrSelect, then stall=0.
- ADD R5,.. with I_WB_Valid/I_WB_DestReg=5 in the same edge while busy[5]=1 -> bypass build issues; busy[5] ends 1.
- I_GPUStallSignal=1 for 3 cycles with a valid non-hazard instruction -> outputs frozen, O_DepStallSignal=1; issues on the first cycle after release.
- Stream of 8'hFF IR with I_FE_Valid=1 -> no stall, O_DE_Valid=0, scoreboard unchanged.

Source files
------------

// File: rtl/decode_hazard_unit_pkg.sv
// rtl/decode_hazard_unit_pkg.sv - shared decode constants: widths, field positions, opcode classes, bubble encoding
package decode_hazard_unit_pkg;

    localparam int PC_WIDTH = 16;
    localparam int IR_WIDTH = 32;

    localparam logic [IR_WIDTH-1:0] NOP_IR_ENC = 32'hFF000000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 24;
    localparam int DST_HI    = 23;
    localparam int DST_LO    = 20;
    localparam int SRC1_HI   = 19;
    localparam int SRC1_LO   = 16;
    localparam int SRC2_HI   = 15;
    localparam int SRC2_LO   = 12;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_ADDI   = 8'h02;
    localparam logic [7:0] OP_MOVI   = 8'h03;
    localparam logic [7:0] OP_BR     = 8'h10;
    localparam logic [7:0] OP_JMP    = 8'h11;
    localparam logic [7:0] OP_ST     = 8'h20;
    localparam logic [7:0] OP_BUBBLE = 8'hFF;

    typedef enum logic {
        ST_IDLE,
        ST_BR_PEND
    } br_state_e;

    typedef struct packed {
        logic writes_dst;
        logic reads_src1;
        logic reads_src2;
        logic is_branch;
    } op_class_t;

    // Unlisted opcodes (including the bubble) neither read nor write registers.
    function automatic op_class_t op_class(input logic [7:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_ADD:  c = '{writes_dst: 1'b1, reads_src1: 1'b1, reads_src2: 1'b1, is_branch: 1'b0};
            OP_ADDI: c = '{writes_dst: 1'b1, reads_src1: 1'b1, reads_src2: 1'b0, is_branch: 1'b0};
            OP_MOVI: c = '{writes_dst: 1'b1, reads_src1: 1'b0, reads_src2: 1'b0, is_branch: 1'b0};
            OP_ST:   c = '{writes_dst: 1'b0, reads_src1: 1'b1, reads_src2: 1'b1, is_branch: 1'b0};
            OP_BR:   c = '{writes_dst: 1'b0, reads_src1: 1'b1, reads_src2: 1'b0, is_branch: 1'b1};
            OP_JMP:  c = '{writes_dst: 1'b0, reads_src1: 1'b0, reads_src2: 1'b0, is_branch: 1'b1};
            OP_NOP:  c = '0;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_hazard_unit_scoreboard.sv
// rtl/decode_hazard_unit_scoreboard.sv - in-flight register writer busy bits; DE_WB_BYPASS_EN forwards same-cycle writeback
module decode_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]  busy_eff
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
    end

    // Set is OR-ed after the clear so a new writer on a retiring register keeps it busy.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end

`ifdef DE_WB_BYPASS_EN
    assign busy_eff = busy & ~clr_mask;
`else
    assign busy_eff = busy;
`endif

endmodule

// File: rtl/decode_hazard_unit.sv
// rtl/decode_hazard_unit.sv - decode stage: hazard/branch stall generation and issue; optional DE_WB_BYPASS_EN
module decode_hazard_unit
    import decode_hazard_unit_pkg::*;
#(
    parameter int                  NUM_REGS  = 16,
    parameter int                  REG_IDX_W = 4,
    parameter logic [IR_WIDTH-1:0] NOP_IR    = NOP_IR_ENC
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_LOCK,
    input  logic [PC_WIDTH-1:0]  I_PC,
    input  logic [IR_WIDTH-1:0]  I_IR,
    input  logic                 I_FE_Valid,
    input  logic                 I_BranchAddrSelect,
    input  logic                 I_GPUStallSignal,
    input  logic                 I_WB_Valid,
    input  logic [REG_IDX_W-1:0] I_WB_DestReg,
    output logic                 O_LOCK,
    output logic                 O_BranchStallSignal,
    output logic                 O_DepStallSignal,
    output logic                 O_DE_Valid,
    output logic [PC_WIDTH-1:0]  O_PC,
    output logic [IR_WIDTH-1:0]  O_IR,
    output logic [REG_IDX_W-1:0] O_DestReg,
    output logic                 O_DestValid
);

    logic [7:0]           opcode;
    logic [REG_IDX_W-1:0] dst;
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    op_class_t            cls;
    logic                 bubble;
    logic [NUM_REGS-1:0]  busy_eff;
    logic                 hazard;
    logic                 issue;
    br_state_e            state;
    br_state_e            state_n;

    assign opcode = I_IR[OPCODE_HI:OPCODE_LO];
    assign dst    = I_IR[DST_HI:DST_LO];
    assign src1   = I_IR[SRC1_HI:SRC1_LO];
    assign src2   = I_IR[SRC2_HI:SRC2_LO];
    assign cls    = op_class(opcode);
    assign bubble = (opcode == OP_BUBBLE);

    assign hazard = I_FE_Valid & ~bubble &
                    ((cls.reads_src1 & busy_eff[src1]) |
                     (cls.reads_src2 & busy_eff[src2]) |
                     (cls.writes_dst & busy_eff[dst]));

    assign O_BranchStallSignal = (state == ST_BR_PEND);
    assign O_DepStallSignal    = I_GPUStallSignal | (I_LOCK & hazard & ~O_BranchStallSignal);

    assign issue = I_LOCK & I_FE_Valid & ~hazard & ~O_BranchStallSignal &
                   ~I_GPUStallSignal & ~bubble;

    // While idle the scoreboard is frozen entirely, writeback included.
    decode_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_sb (
        .clk      (I_CLOCK),
        .rst      (I_RESET),
        .set_en   (issue & cls.writes_dst),
        .set_idx  (dst),
        .clr_en   (I_LOCK & I_WB_Valid),
        .clr_idx  (I_WB_DestReg),
        .busy_eff (busy_eff)
    );

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) state <= ST_IDLE;
        else         state <= state_n;
    end

    // A newly issued branch outranks the resolve of the previous one.
    always_comb begin
        state_n = state;
        if (!I_LOCK)
            state_n = ST_IDLE;
        else if (issue && cls.is_branch)
            state_n = ST_BR_PEND;
        else if (state == ST_BR_PEND && I_BranchAddrSelect)
            state_n = ST_IDLE;
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            O_LOCK      <= 1'b0;
            O_DE_Valid  <= 1'b0;
            O_PC        <= '0;
            O_IR        <= NOP_IR;
            O_DestReg   <= '0;
            O_DestValid <= 1'b0;
        end else begin
            O_LOCK <= I_LOCK;
            if (!I_LOCK) begin
                O_DE_Valid  <= 1'b0;
                O_IR        <= NOP_IR;
                O_DestValid <= 1'b0;
            end else if (I_GPUStallSignal) begin
                O_DE_Valid  <= O_DE_Valid;
            end else if (issue) begin
                O_DE_Valid  <= 1'b1;
                O_PC        <= I_PC;
                O_IR        <= I_IR;
                O_DestReg   <= dst;
                O_DestValid <= cls.writes_dst;
            end else begin
                O_DE_Valid  <= 1'b0;
                O_IR        <= NOP_IR;
                O_DestValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_unit.sv
// tb/tb_decode_hazard_unit.sv - self-checking bench for decode_hazard_unit with a behavioural reference model
module tb_decode_hazard_unit;

`ifdef DE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'hFF000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        fe_valid, bas, gpu, wb_valid;
    logic [3:0]  wb_dst;
    logic        o_lock, o_br_stall, o_dep_stall, o_de_valid, o_dest_valid;
    logic [15:0] o_pc;
    logic [31:0] o_ir;
    logic [3:0]  o_dest;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // reference state
    logic [15:0] m_busy;
    bit          m_pend;
    logic        m_dev, m_dv, m_lock;
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_dst;
    bit          m_issued;

    always #5 clk = ~clk;

    decode_hazard_unit dut (
        .I_CLOCK             (clk),
        .I_RESET             (rst),
        .I_LOCK              (lock),
        .I_PC                (pc),
        .I_IR                (ir),
        .I_FE_Valid          (fe_valid),
        .I_BranchAddrSelect  (bas),
        .I_GPUStallSignal    (gpu),
        .I_WB_Valid          (wb_valid),
        .I_WB_DestReg        (wb_dst),
        .O_LOCK              (o_lock),
        .O_BranchStallSignal (o_br_stall),
        .O_DepStallSignal    (o_dep_stall),
        .O_DE_Valid          (o_de_valid),
        .O_PC                (o_pc),
        .O_IR                (o_ir),
        .O_DestReg           (o_dest),
        .O_DestValid         (o_dest_valid)
    );

    // {writes dst, reads src1, reads src2, is branch}
    function automatic logic [3:0] attrs(input logic [7:0] op);
        case (op)
            8'h01:   return 4'b1110;
            8'h02:   return 4'b1100;
            8'h03:   return 4'b1000;
            8'h20:   return 4'b0110;
            8'h10:   return 4'b0101;
            8'h11:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, s2, 12'h000};
    endfunction

    function automatic bit m_hazard();
        logic [3:0]  a;
        logic [15:0] eff;
        a   = attrs(ir[31:24]);
        eff = m_busy;
        if (BYPASS && wb_valid && lock) eff[wb_dst] = 1'b0;
        if (!fe_valid || ir[31:24] == 8'hFF) return 1'b0;
        return (a[2] && eff[ir[19:16]]) || (a[1] && eff[ir[15:12]]) || (a[3] && eff[ir[23:20]]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_pend = 0; m_dev = 0; m_pc = '0; m_ir = NOP; m_dst = '0; m_dv = 0; m_lock = 0;
    endtask

    task automatic model_edge();
        logic [3:0] a;
        bit h;
        a = attrs(ir[31:24]);
        h = m_hazard();
        m_issued = lock && fe_valid && !h && !m_pend && !gpu && (ir[31:24] != 8'hFF);
        if (lock && wb_valid) m_busy[wb_dst] = 1'b0;
        if (m_issued && a[3]) m_busy[ir[23:20]] = 1'b1;
        if (!lock) m_pend = 0;
        else if (m_issued && a[0]) m_pend = 1;
        else if (m_pend && bas) m_pend = 0;
        if (!lock || (!gpu && !m_issued)) begin
            m_dev = 0; m_ir = NOP; m_dv = 0;
        end else if (m_issued) begin
            m_dev = 1; m_pc = pc; m_ir = ir; m_dst = ir[23:20]; m_dv = a[3];
        end
        m_lock = lock;
    endtask

    task automatic check_outputs();
        chk("de_valid",  o_de_valid,   m_dev);
        chk("pc",        o_pc,         m_pc);
        chk("ir",        o_ir,         m_ir);
        chk("dest",      o_dest,       m_dst);
        chk("dest_valid", o_dest_valid, m_dv);
        chk("br_stall",  o_br_stall,   m_pend);
        chk("lock",      o_lock,       m_lock);
        chk("busy",      dut.u_sb.busy, m_busy);
    endtask

    // Inputs are set just after a posedge; combinational check, then negedge update.
    task automatic step();
        #1;
        chk("dep_stall", o_dep_stall, gpu | (lock & m_hazard() & !m_pend));
        model_edge();
        @(negedge clk);
        #1;
        check_outputs();
        @(posedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [15:0] p);
        fe_valid = v; ir = instr; pc = p;
    endtask

    task automatic clear_all();
        fe_valid = 0;
        for (int r = 0; r < 16; r++) begin
            wb_valid = 1; wb_dst = 4'(r);
            step();
        end
        wb_valid = 0;
    endtask

    logic [7:0] ops [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'hFF};

    initial begin
        rst = 1; lock = 0; pc = '0; ir = '0; fe_valid = 0; bas = 0; gpu = 0; wb_valid = 0; wb_dst = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_dep", o_dep_stall, 1'b0);
        rst = 0;
        lock = 1;

        // RAW on R1, released by writeback
        drive(1, ins(8'h01, 4'd1, 4'd2, 4'd3), 16'h0004); step();
        chk("add_issue", o_de_valid, 1'b1);
        drive(1, ins(8'h01, 4'd4, 4'd1, 4'd1), 16'h0008); step();
        chk("raw_bubble", o_ir, NOP);
        step();
        wb_valid = 1; wb_dst = 4'd1; step();
        chk("wb_cycle_issue", o_de_valid, BYPASS);
        wb_valid = 0;
        if (!m_issued) begin
            step();
            chk("late_issue", o_de_valid, 1'b1);
        end
        fe_valid = 0; step();
        clear_all();

        // branch blocks fetch until resolve
        drive(1, ins(8'h10, 4'd0, 4'd2, 4'd0), 16'h0010); step();
        chk("br_stall_set", o_br_stall, 1'b1);
        chk("br_pc", o_pc, 16'h0010);
        drive(1, ins(8'h02, 4'd6, 4'd7, 4'd0), 16'h0014);
        repeat (3) step();
        chk("br_drop", o_de_valid, 1'b0);
        bas = 1; step();
        chk("br_resolved", o_br_stall, 1'b0);
        bas = 0;

        // same-edge writeback and new writer on R5
        drive(1, ins(8'h03, 4'd5, 4'd0, 4'd0), 16'h0020); step();
        drive(1, ins(8'h01, 4'd5, 4'd8, 4'd9), 16'h0024);
        wb_valid = 1; wb_dst = 4'd5; step();
        wb_valid = 0;
        if (!m_issued) step();
        chk("r5_busy", dut.u_sb.busy[5], 1'b1);
        fe_valid = 0; clear_all();

        // downstream freeze
        drive(1, ins(8'h03, 4'd10, 4'd0, 4'd0), 16'h0030);
        gpu = 1; repeat (3) step();
        chk("gpu_frozen", o_de_valid, 1'b0);
        gpu = 0; step();
        chk("gpu_release_issue", o_pc, 16'h0030);

        // bubble stream
        drive(1, NOP, 16'h0034);
        repeat (4) step();
        chk("bubble_no_stall", o_dep_stall, 1'b0);
        clear_all();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            lock     = ($urandom_range(15) != 0);
            fe_valid = $urandom_range(1);
            ir       = ins(ops[$urandom_range(7)], 4'($urandom), 4'($urandom), 4'($urandom));
            pc       = 16'($urandom);
            bas      = ($urandom_range(3) == 0);
            gpu      = ($urandom_range(7) == 0);
            wb_valid = $urandom_range(1);
            wb_dst   = 4'($urandom);
            step();
        end
        lock = 1; gpu = 0; bas = 0; wb_valid = 0;
        clear_all();

        // async reset while a branch is pending and R3 busy
        drive(1, ins(8'h03, 4'd3, 4'd0, 4'd0), 16'h0040); step();
        drive(1, ins(8'h11, 4'd0, 4'd0, 4'd0), 16'h0044); step();
        chk("pend_before_reset", o_br_stall, 1'b1);
        fe_valid = 0;
        #2 rst = 1;
        #1;
        model_reset();
        chk("reset_br_stall_now", o_br_stall, 1'b0);
        check_outputs();
        @(posedge clk);
        rst = 0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
